// File: rtl/lut_writer.sv
// lut_writer: loads a LUT from a byte stream. Each entry is two bytes
// (high then low); one write strobe is issued per assembled entry.
// Latency: wr_en rises in the cycle right after the low-byte transfer.
// Backpressure: byte_ready is low in IDLE, WRITE and DONE, so the source
// stalls during the write cycle and when no session is open.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, count      session request (IDLE only) and entry count 0..2**ADDR_W
//   byte_valid/ready  byte stream handshake, byte_data carries the byte
//   wr_en/addr/data   LUT write port
//   busy, done, err   session status; err is a sticky protocol-error flag
module lut_writer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HI    = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        hi_q, hi_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic              accept;
  logic              last_entry;

  assign byte_ready = (state_q == S_HI) || (state_q == S_LO);
  assign accept     = byte_valid && byte_ready;

  // Compared in ADDR_W+1 bits so that count = 2**ADDR_W terminates on the
  // last address without the index ever wrapping.
  assign last_entry = (({1'b0, addr_q} + (ADDR_W+1)'(1)) == cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    data_d  = data_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          cnt_d = count;
          if (count != '0) begin
            addr_d  = '0;
            state_d = S_HI;
          end else begin
            state_d = S_DONE;
          end
        end
        // A byte offered with no session open is a protocol error.
        if (byte_valid) begin
          err_d = 1'b1;
        end
      end
      S_HI: begin
        if (accept) begin
          hi_d    = byte_data;
          state_d = S_LO;
        end
      end
      S_LO: begin
        // The write word is latched here so wr_data only changes as the
        // write cycle begins and holds between writes.
        if (accept) begin
          data_d  = DATA_W'({hi_q, byte_data});
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (last_entry) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_HI;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      hi_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign wr_en   = (state_q == S_WRITE);
  assign done    = (state_q == S_DONE);
  assign busy    = (state_q != S_IDLE);
  assign wr_addr = addr_q;
  assign wr_data = data_q;
  assign err     = err_q;

endmodule

// File: tb/tb_lut_writer.sv
// Bench for lut_writer: directed sessions plus randomized sessions, checked
// cycle by cycle against a session-level reference model (byte pairs ->
// expected writes, busy/ready/done/err derived from session progress).
module tb_lut_writer;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;

  lut_writer #(.ADDR_W(ADDR_W), .DATA_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .count      (count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          addr;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] wr_log[$];   // observed writes: {addr, data}
  int          cyc       = 0;
  bit          mbusy     = 0;
  bit          merr      = 0;
  int          sess_count = 0;
  int          xfers     = 0;
  int          writes_seen = 0;
  int          done_due  = -1;
  int          done_seen = 0;
  logic [7:0]  m_hi      = '0;
  logic [15:0] last_data = '0;

  always @(negedge clk) begin
    bit   exp_wr;
    bit   ready_exp;
    bit   mb_cur;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      mbusy = 0; merr = 0; exp_q.delete(); done_due = -1;
      xfers = 0; last_data = '0; sess_count = 0;
      check("rst_wr_en", wr_en, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", byte_ready, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_wr_addr", wr_addr, 0);
    end else begin
      mb_cur    = mbusy;
      exp_wr    = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      ready_exp = mbusy && (xfers < 2 * sess_count) && !exp_wr;

      check("busy", busy, mbusy);
      check("done", done, (cyc == done_due));
      check("err", err, merr);
      check("byte_ready", byte_ready, ready_exp);
      check("wr_en", wr_en, exp_wr);

      if (done) done_seen++;
      if (wr_en) wr_log.push_back({16'(wr_addr), wr_data});

      if (exp_wr) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), e.addr);
        check("wr_data", wr_data, e.data);
        last_data = e.data;
        writes_seen++;
        if (writes_seen == sess_count) done_due = cyc + 1;
      end else begin
        check("wr_data_hold", wr_data, last_data);
      end

      if (byte_valid && ready_exp) begin
        if (xfers % 2 == 0) begin
          m_hi = byte_data;
        end else begin
          e.addr = xfers / 2;
          e.data = {m_hi, byte_data};
          e.due  = cyc + 1;
          exp_q.push_back(e);
        end
        xfers++;
      end

      if (cyc == done_due) mbusy = 0;
      if (!mb_cur && start) begin
        mbusy = 1; merr = 0;
        sess_count = int'(count);
        xfers = 0; writes_seen = 0; done_seen = 0;
        exp_q.delete();
        if (count == 0) done_due = cyc + 1;
      end
      if (!mb_cur && byte_valid) merr = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_sess(input int n);
    start = 1'b1;
    count = (ADDR_W+1)'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) check("ready_timeout", 0, 1);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int t = 0;
    while ((mbusy || busy) && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (t >= limit) check("idle_timeout", 0, 1);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; count = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Two entries, bytes back-to-back.
    wr_log.delete();
    start_sess(2);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h12); send_byte(8'h34);
    wait_idle(20);
    check("t1_nwr", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("t1_wr0", wr_log[0], {16'd0, 16'hABCD});
      check("t1_wr1", wr_log[1], {16'd1, 16'h1234});
    end
    check("t1_done_cnt", done_seen, 1);

    // Zero-length session.
    wr_log.delete();
    start_sess(0);
    wait_idle(10);
    check("t2_nwr", wr_log.size(), 0);
    check("t2_done_cnt", done_seen, 1);

    // One entry with a 5-cycle stall between the bytes.
    wr_log.delete();
    start_sess(1);
    send_byte(8'h5A);
    repeat (5) tick();
    send_byte(8'hC3);
    wait_idle(20);
    check("t3_nwr", wr_log.size(), 1);
    if (wr_log.size() == 1) check("t3_wr0", wr_log[0], {16'd0, 16'h5AC3});

    // Full depth, incrementing data.
    wr_log.delete();
    start_sess(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'h10 + 8'(i >> 8));
      send_byte(8'(i));
    end
    wait_idle(20);
    check("t4_nwr", wr_log.size(), DEPTH);
    if (wr_log.size() == DEPTH) begin
      check("t4_first", wr_log[0], {16'd0, 16'h1000});
      check("t4_last", wr_log[DEPTH-1], {16'(DEPTH-1), 16'h10FF});
    end
    check("t4_done_cnt", done_seen, 1);

    // Sticky error, cleared by start; second start during session ignored.
    byte_valid = 1'b1; byte_data = 8'hEE;
    tick();
    byte_valid = 1'b0;
    repeat (3) tick();
    check("t5_err_set", err, 1);
    wr_log.delete();
    start_sess(1);
    check("t5_err_clr", err, 0);
    start = 1'b1; count = (ADDR_W+1)'(3);
    tick();
    start = 1'b0;
    send_byte(8'h77); send_byte(8'h88);
    wait_idle(20);
    check("t5_nwr", wr_log.size(), 1);
    if (wr_log.size() == 1) check("t5_wr0", wr_log[0], {16'd0, 16'h7788});
    check("t5_idle_busy", busy, 0);

    // Randomized sessions with random source stalls.
    for (int s = 0; s < 25; s++) begin
      n = int'($urandom_range(0, 6));
      wr_log.delete();
      start_sess(n);
      for (int b = 0; b < 2 * n; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_byte(8'($urandom));
      end
      wait_idle(20);
      check("rnd_nwr", wr_log.size(), n);
      check("rnd_done_cnt", done_seen, 1);
      repeat ($urandom_range(0, 3)) tick();
    end

    // Reset after the high byte of entry 3.
    wr_log.delete();
    start_sess(6);
    for (int b = 0; b < 7; b++) send_byte(8'(b + 1));
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_busy", busy, 0);
    check("t6_async_ready", byte_ready, 0);
    check("t6_async_addr", wr_addr, 0);
    check("t6_async_data", wr_data, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t6_nwr", wr_log.size(), 3);
    check("t6_idle", busy, 0);
    start_sess(2);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    wait_idle(20);
    check("t6_nwr2", wr_log.size(), 5);
    if (wr_log.size() == 5) begin
      check("t6_wr0", wr_log[3], {16'd0, 16'hDEAD});
      check("t6_wr1", wr_log[4], {16'd1, 16'hBEEF});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lut_writer.md
LUT_WRITER -- requirements
Module: lut_writer

Interface
REQ-001 Parameter ADDR_W, default 8, address width of the LUT being programmed (depth 2**ADDR_W).
REQ-002 Parameter DATA_W, fixed at 16, LUT entry width; each entry is assembled from two bytes.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a load session; sampled only in IDLE.
REQ-006 count  input  ADDR_W+1  number of entries to write (0..2**ADDR_W), captured on accepted start.
REQ-007 byte_valid  input  1  source asserts when byte_data holds a byte.
REQ-008 byte_data  input  8  stream byte.
REQ-009 byte_ready  output  1  block can accept a byte this cycle.
REQ-010 wr_en  output  1  one-cycle LUT write strobe.
REQ-011 wr_addr  output  ADDR_W  LUT write address.
REQ-012 wr_data  output  16  LUT write data.
REQ-013 busy  output  1  high from accepted start until the cycle after done.
REQ-014 done  output  1  one-cycle pulse at session completion.
REQ-015 err  output  1  sticky protocol error flag.

Function
REQ-016 FSM states: IDLE, HI, LO, WRITE, DONE.
REQ-017 A byte transfers only in a cycle where byte_valid and byte_ready are both 1.
REQ-018 byte_ready is 1 in HI and LO, 0 in IDLE, WRITE and DONE.
REQ-019 IDLE: start=1 with count>0 captures count, clears wr_addr to 0, clears err, and moves to HI.
REQ-020 IDLE: start=1 with count=0 clears err and moves directly to DONE; no write occurs.
REQ-021 HI: an accepted byte is stored as bits [15:8] of the entry, and the FSM moves to LO; otherwise it stays in HI.
REQ-022 LO: an accepted byte is stored as bits [7:0], and the FSM moves to WRITE; otherwise it stays in LO.
REQ-023 WRITE: wr_en=1 for exactly this cycle, with wr_data = {hi,lo} and wr_addr = current entry index.
REQ-024 Latency: wr_en is asserted in the cycle immediately after the low-byte transfer.
REQ-025 Leaving WRITE: if entries written == captured count, go to DONE; else increment wr_addr by 1 and go to HI.
REQ-026 wr_addr never wraps within a session; count = 2**ADDR_W writes addresses 0..2**ADDR_W-1, and the final write goes to DONE without incrementing.
REQ-027 DONE: done=1 for one cycle, then go to IDLE.
REQ-028 busy=1 in HI, LO, WRITE and DONE, 0 in IDLE.
REQ-029 start while busy is ignored and has no effect on state, count or address.
REQ-030 byte_valid=1 in IDLE sets err; err holds until the next accepted start.
REQ-031 wr_en=0 in all states except WRITE; wr_data and wr_addr hold their values outside WRITE.

Reset
REQ-032 rst_n low immediately forces IDLE, with wr_en=0, done=0, busy=0, byte_ready=0, err=0, wr_addr=0, wr_data=0, and the captured count and byte registers at 0.
REQ-033 Reset mid-session abandons the session; no further writes occur; after release the block waits in IDLE for a new start.

Verification
REQ-034 start, count=2; bytes 0xAB,0xCD,0x12,0x34 back-to-back -> wr_en at addr 0 data 0xABCD, then at addr 1 data 0x1234; done one cycle after the second write; busy then low.
REQ-035 start, count=0 -> done pulses next cycle; wr_en never asserts; byte_ready stays 0.
REQ-036 count=1; byte_valid low for 5 cycles between the high and low byte -> FSM holds in LO; exactly one write (addr 0) follows the low byte by one cycle.
REQ-037 Full depth count=2**ADDR_W with incrementing data -> writes at addresses 0..2**ADDR_W-1, each with the correct 16-bit word; no wrap to 0; a single done pulse.
REQ-038 byte_valid=1 in IDLE -> err=1 and remains 1; next start clears it; a second start during the session is ignored.
REQ-039 rst_n asserted after the high byte of entry 3 -> outputs go to reset values asynchronously; no write to addr 3; a new start then writes from addr 0.
